// File: rtl/int_sched.sv
// Interrupt scheduler: masked level/edge sources, nesting-aware priority
// against the in-service bitmap, registered irq + vector toward cpu_status.
module int_sched #(
    parameter int          N_SRC    = 8,
    parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic [N_SRC-1:0] src,
    input  logic             int_ack,
    input  logic             restore,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       cfg_rdata,
    output logic             irq,
    output logic [15:0]      vec_k
);
    localparam int WW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic {IDLE, REQ} state_e;

    state_e            state_q, state_d;
    logic              irq_q, irq_d;
    logic [15:0]       vec_q, vec_d;
    logic [WW-1:0]     win_q, win_d, cand;
    logic [N_SRC-1:0]  mask_q, edge_q, epend_q, isr_q, src_q;
    logic [N_SRC-1:0]  epend_d, isr_d, wdat, rise, w1c, win_oh, ack_oh;
    logic [N_SRC-1:0]  req, isr_low, allowed, qual, rd;
    logic              ack, win_still;

    assign wdat = cfg_wdata[N_SRC-1:0];
    assign rise = edge_q & src & ~src_q;
    assign w1c  = (cfg_we && cfg_addr == 2'd2) ? (wdat & edge_q) : '0;
    assign ack  = int_ack && (state_q == REQ);

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N_SRC; i++) win_oh[i] = (win_q == WW'(i));
    end

    assign ack_oh  = ack ? win_oh : '0;
    assign epend_d = (epend_q & ~(w1c | ack_oh)) | rise;
    assign req     = (epend_q & edge_q) | (src & ~edge_q);

    // Only indices strictly below the lowest in-service bit may preempt;
    // with isr empty the subtraction wraps to all-ones.
    assign isr_low = isr_q & (~isr_q + N_SRC'(1));
    assign allowed = isr_low - N_SRC'(1);
    assign qual    = req & mask_q & allowed;
    assign isr_d   = (isr_q & ~(restore ? isr_low : '0)) | ack_oh;

    always_comb begin
        cand = '0;
        for (int i = N_SRC - 1; i >= 0; i--) if (qual[i]) cand = WW'(i);
    end

    // A W1C landing this cycle withdraws immediately unless a new edge re-sets it.
    assign win_still = |(win_oh & mask_q &
                         ((epend_q & edge_q & ~w1c) | rise | (src & ~edge_q)));

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= VEC_BASE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (|qual) state_d = REQ;
            REQ:  if (ack || !win_still) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_d = (state_d == REQ);
        win_d = win_q;
        vec_d = vec_q;
        if (state_q == IDLE && |qual) begin
            win_d = cand;
            vec_d = VEC_BASE + (16'(cand) << 1);
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            mask_q  <= '0;
            edge_q  <= '0;
            epend_q <= '0;
            isr_q   <= '0;
            src_q   <= '0;
        end else begin
            if (cfg_we && cfg_addr == 2'd0) mask_q <= wdat;
            if (cfg_we && cfg_addr == 2'd1) edge_q <= wdat;
            epend_q <= epend_d;
            isr_q   <= isr_d;
            src_q   <= src;
        end
    end

    always_comb begin
        case (cfg_addr)
            2'd0:    rd = mask_q;
            2'd1:    rd = edge_q;
            2'd2:    rd = req;
            default: rd = isr_q;
        endcase
    end

    // Live level bits would otherwise leak through pend while held in reset.
    assign cfg_rdata = a_rst ? 8'(rd) : 8'h00;
    assign irq       = irq_q;
    assign vec_k     = vec_q;
endmodule

// File: doc/int_sched.md
# int_sched

Interrupt scheduler placed ahead of `cpu_status`. It collects up to eight external interrupt sources and applies a per-source mask and trigger mode. It prioritises pending requests against the nesting level currently in service, and presents a single `irq` plus a 16-bit vector to `cpu_status`. In-service tracking is driven by `int_ack` (entry) and `restore` (RTI), so higher-priority sources preempt lower ones.

## Interface
- `N_SRC`, 8, number of sources (1..8); index 0 is highest priority
- `VEC_BASE`, 16'hFFE0, vector of source 0; source i uses `VEC_BASE + 2*i`

Ports:
- `clk` in 1: the block's single clock
- `a_rst` in 1: reset, asynchronous, active-low
- `src` in N_SRC: interrupt sources, synchronous to `clk`, active-high
- `int_ack` in 1: one-cycle pulse from `cpu_status` when the vector is taken
- `restore` in 1: one-cycle pulse on RTI completion
- `cfg_we` in 1: configuration write strobe
- `cfg_addr` in 2: register select (0 mask, 1 edge, 2 pending, 3 in-service)
- `cfg_wdata` in 8: write data; bits ≥ N_SRC are ignored
- `cfg_rdata` out 8: combinational read of the selected register; bits ≥ N_SRC read 0
- `irq` out 1: registered request to `cpu_status`
- `vec_k` out 16: registered vector of the latched winner

## Operation
Registers:
- `mask`: R/W; 1 enables the source.
- `edge`: R/W; 1 selects rising-edge trigger, 0 selects level trigger.
- `pend`: read returns edge-latched bits OR live level bits; write is W1C on edge bits only.
- `isr`: read-only in-service bitmap.

Reset values (all taken while `a_rst`=0):
- `mask`=0, `edge`=0, `pend`=0, `isr`=0
- `src_q` (previous src)=0
- state IDLE, `irq`=0, `vec_k`=`VEC_BASE`, `win`=0

Per-source request and candidate selection:
- Edge-mode request: latched bit set when `src & ~src_q`. Cleared by W1C, or by `int_ack` for the latched winner. Set wins over a clear in the same cycle.
- Level-mode request: live `src` value; never latched.
- `cand` = lowest index i with request & `mask`[i] & (i < lowest set bit of `isr`). If `isr`=0, any index qualifies.

State machine (2 states):
- IDLE: if `cand` is valid, latch `win`=cand, set `vec_k`=`VEC_BASE+2*win`, `irq`<=1, go to REQ.
- REQ: `win` and `vec_k` are frozen (no re-prioritisation).
  - On `int_ack`: set `isr[win]`, clear the edge pending bit of `win`, `irq`<=0, go to IDLE.
  - Otherwise, if the request for `win` disappears (level drops, mask cleared, or W1C): `irq`<=0, go to IDLE without touching `isr`.
  - `int_ack` wins over a simultaneous withdrawal.
- `int_ack` in IDLE is ignored.
- `restore`: at the edge, clear the lowest-index set bit of `isr`. No effect if `isr`=0.
- `restore` and `int_ack` together: the restore clear is computed on the old `isr`, then `isr[win]` is set. If both target the same bit, the set wins.
- Writes to `mask`/`edge` take effect at the next edge. Changing `edge` 0→1 does not create a latched bit unless a rising edge occurs.

## Timing
- Level source high sampled at edge E0 → `irq`=1 after E0 (latency 1).
- Edge source rising at E0 → pending latched at E0 → `irq`=1 after E1 (latency 2).
- `int_ack` sampled at edge E → `irq`=0 after E.
  - Earliest re-assertion is after E+1, since IDLE evaluates using the updated `isr`. This gives at least one cycle of `irq` low between grants.
- `vec_k` is valid whenever `irq`=1 and is stable throughout REQ.
- `a_rst` asserted mid-REQ: `irq` drops immediately (asynchronously), and all state is lost.

## Test plan
- Reset: drive `a_rst`=0 with `src`=8'hFF → `irq`=0, `vec_k`=16'hFFE0, all `cfg_rdata` reads return 0.
- Level mode:
  - mask=8'h08, src[3]=1 → `irq`=1 one cycle later, `vec_k`=16'hFFE6.
  - Pulse `int_ack` → `isr`=8'h08, `irq`=0, and `irq` stays 0 while src[3] remains high.
  - Pulse `restore` → `isr`=0, and `irq` re-asserts one cycle later.
- Edge and W1C:
  - edge=mask=8'h01, one-cycle pulse on src[0] → `pend`=8'h01, `irq`=1 two edges after the pulse.
  - Write `pend`=8'h01 while in REQ → `irq` falls the next cycle and no `isr` bit is set.
- Nesting: mask=8'hFF, level src[5] acknowledged (`isr`=8'h20). Raise src[2] → `irq`=1 with `vec_k`=16'hFFE4. Raise src[7] instead → no `irq`.
- Simultaneous events:
  - Edge on src[1] in the same cycle as W1C of bit 1 → `pend` bit stays 1.
  - `restore` and `int_ack` in the same cycle with `isr`=8'h20 and win=2 → `isr`=8'h04.
- Withdrawal: level src[4] reaches REQ, then src[4] drops before `int_ack` → `irq`=0 next cycle, `isr` unchanged. A later `int_ack` in IDLE is ignored.
